bdc_motor_ctrl: RTL and testbench
=================================

Name: bdc_motor_ctrl

Overview:
Three-channel brushed-DC motor controller with an SPI register interface. It provides per-channel 8-bit PWM with direction and cycle-by-cycle current limiting, and per-channel quadrature tachometer counters. A global motor enable is guarded by an SPI-kicked watchdog. The block is the top-level core between an external SPI host and three H-bridge drivers.

Parameters:
PWM_PRESCALE, 4, clk cycles per PWM counter step (PWM period = 256*PWM_PRESCALE clk).
WDOG_UNIT, 64, clk cycles per watchdog divisor count.
HW_CONFIG, 8'h30, read-only value of register 0xD (channel count 3 in bits 7:4).

Ports:
clk  in  1  system clock; all logic is in this domain.
reset  in  1  asynchronous, active-high reset.
sclk  in  1  SPI clock; idles high; asynchronous to clk.
ss  in  1  SPI select, active-high.
mosi  in  1  SPI data in; host changes it on falling sclk.
miso  out  1  SPI data out; high-Z when ss is low.
tstn  in  1  test strap, active-low; status only.
wdogdisn  in  1  low disables the watchdog.
currentlimit0..2  in  1 each  over-current flag per channel, active-high.
tach0..2  in  2 each  quadrature tach inputs per channel.
motorena  out  1  global motor enable.
pwm0..2  out  2 each  bridge drive per channel: [0] forward, [1] reverse.

Behaviour:
- Synchronizers: sclk, ss, mosi, tach*, currentlimit*, tstn and wdogdisn each pass through a 2-FF synchronizer.
- SPI edge detection: a rising sclk edge is detected on the synchronized signal.
- SPI timing requirement: sclk period >= 4 clk, each phase >= 2 clk.
- SPI sampling: mosi is sampled on the rising-edge detect cycle.
- SPI output: the miso shift register also advances on that detect cycle, so miso changes <= 3 clk after a rising sclk edge.
- SPI frame: 16 bits, MSB first.
  - Byte 0 = {rw, addr[3:0], 3'b000}; rw=1 means read.
  - Byte 1 = write data on mosi, or read data on miso.
- Read: after the 8th bit, the addressed register is latched into the miso shifter and output MSB-first over bits 9-16.
- During byte 0 and during writes, miso outputs 0.
- Write: the register is updated on the 16th-bit detect cycle.
- Deasserting ss clears the bit counter. Frames with fewer than 16 bits are discarded: no write, no watchdog kick.
- Bits after the 16th are ignored until ss falls. sclk activity while ss is low is ignored.
- Register map:
  - Channel n (n=0,1,2) at base 4n:
    - +0 duty (R/W, reset 0x00).
    - +1 tach count (RO).
    - +2 config (R/W, reset 0x00): bit0 = direction, bit1 = brake.
    - +3 status (RO): {5'b0, currentlimit_sync, tach_sync[1:0]}.
  - 0xC reads 0x00.
  - 0xD reads HW_CONFIG.
  - 0xE watchdog divisor (R/W, reset 0xFF).
  - 0xF watchdog control:
    - bits[3:0] R/W; bit3 = motor enable.
    - bits[6:4] read 0.
    - bit7 = tripped, sticky; writing bit7=1 clears it and restarts the counter. bits[3:0] are written in the same access.
- motorena = ctrl[3] & ~tripped. Reset value 0.
- PWM: a free-running 8-bit counter advances every PWM_PRESCALE clk. The raw PWM signal is high while counter < duty; duty 0 gives 0%, 0x40 gives 25%, 0xC0 gives 75%.
- Current limit: currentlimit_sync high forces the raw PWM low until the counter wraps to 0 (cycle-by-cycle limit).
- PWM output routing:
  - direction 0: pwm[0] = raw, pwm[1] = 0.
  - direction 1: pwm[0] = 0, pwm[1] = raw.
- PWM forcing: pwm = 2'b00 when brake=1 or motorena=0. All pwm outputs reset to 0.
- Tach: quadrature decode on the synchronized pair into an 8-bit up/down counter, wrapping.
  - Forward sequence 00→01→11→10→00 counts +1 per transition; the reverse sequence counts -1.
  - A 2-bit jump leaves the counter unchanged.
  - Reset value 0.
- Watchdog:
  - Counts clk only while ctrl[3]=1, wdogdisn_sync=1, divisor≠0 and not tripped; otherwise it holds.
  - Any completed 16-bit frame clears the count.
  - When the count reaches divisor*WDOG_UNIT, tripped is set.
  - If a trip and a clearing write coincide, the clear wins.

Decomposition:
- Shared package: register address constants, field bit positions, HW_CONFIG, reset values.
- Sub-module bdc_channel (duty/config registers, PWM, current limit, tach decoder) instantiated three times.
- SPI shifter, register decode and watchdog stay in the top level.

Test Plan:
- Reset, then read 0xD -> miso returns 0x30; with ss low, miso is high-Z.
- Write 0xE=0x10, then write 0xF=0x01/0x03/0x07 -> each read of 0xF returns the written value; motorena stays 0.
- Write 0xF=0x0F -> motorena=1. Send no frames for 100 µs -> read 0xF returns 0x8F, motorena=0. Write 0x80 then 0x0F -> read returns 0x0F, motorena=1.
- Drive wdogdisn=0 with 0xF=0x0F and idle 200 µs -> no trip, motorena stays 1.
- Drive tach0 00→01 -> read 0x1 returns 0x01. Drive 01→00 -> read 0x1 returns 0x00.
- Write 0x0 = 0x40 / 0xC0 / 0x80 -> pwm0[0] duty is 25% / 75% / 50% and pwm0[1]=0. Repeat at 0x4 and 0x8 for pwm1 and pwm2. Assert currentlimit0 mid-cycle -> pwm0 is low until the counter wraps.

Source files
------------

// File: rtl/bdc_motor_ctrl_pkg.sv
// Shared definitions for the three-channel brushed-DC motor controller:
// register map, field positions, reset values and the quadrature helper.
package bdc_motor_ctrl_pkg;

  localparam logic [7:0] HW_CONFIG_DEF = 8'h30;

  // Per-channel register offsets (address bits [1:0]).
  localparam logic [1:0] CH_DUTY = 2'd0;
  localparam logic [1:0] CH_TACH = 2'd1;
  localparam logic [1:0] CH_CFG  = 2'd2;
  localparam logic [1:0] CH_STAT = 2'd3;

  localparam logic [3:0] ADDR_ZERO  = 4'hC;
  localparam logic [3:0] ADDR_HWCFG = 4'hD;
  localparam logic [3:0] ADDR_WDIV  = 4'hE;
  localparam logic [3:0] ADDR_WCTL  = 4'hF;

  localparam int CFG_DIR   = 0;
  localparam int CFG_BRAKE = 1;
  localparam int WCTL_MENA = 3;
  localparam int WCTL_TRIP = 7;

  localparam logic [7:0] DUTY_RST = 8'h00;
  localparam logic [1:0] CFG_RST  = 2'b00;
  localparam logic [7:0] WDIV_RST = 8'hFF;
  localparam logic [3:0] WCTL_RST = 4'h0;

  // Maps the gray-coded tach pair 00,01,11,10 onto positions 0,1,2,3.
  function automatic logic [1:0] quad_pos(input logic [1:0] ab);
    return {ab[1], ab[1] ^ ab[0]};
  endfunction

endpackage

// File: rtl/bdc_channel.sv
// One motor channel: duty/config registers, PWM with cycle-by-cycle current
// limit and direction routing, and the quadrature tachometer counter.
module bdc_channel
  import bdc_motor_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [1:0] rd_addr,
  output logic [7:0] rd_data,
  input  logic [7:0] pwm_cnt,
  input  logic       pwm_wrap,
  input  logic       motorena,
  input  logic       climit,
  input  logic [1:0] tach,
  output logic [1:0] pwm
);

  logic [7:0] duty_q, duty_d;
  logic [1:0] cfg_q, cfg_d;
  logic [7:0] tach_cnt_q, tach_cnt_d;
  logic [1:0] tach_prev_q, tach_prev_d;
  logic [1:0] pwm_q, pwm_d;
  logic       climit_hold_q, climit_hold_d;
  logic       raw;
  logic [1:0] step;

  assign raw  = (pwm_cnt < duty_q) & ~climit & ~climit_hold_q;
  assign step = quad_pos(tach) - quad_pos(tach_prev_q);

  always_comb begin
    duty_d        = duty_q;
    cfg_d         = cfg_q;
    tach_cnt_d    = tach_cnt_q;
    tach_prev_d   = tach;
    // An over-current event keeps the output off until the PWM period restarts.
    climit_hold_d = climit | (climit_hold_q & ~pwm_wrap);
    pwm_d         = 2'b00;
    if (wr_en && wr_addr == CH_DUTY) duty_d = wr_data;
    if (wr_en && wr_addr == CH_CFG)  cfg_d  = wr_data[1:0];
    if (step == 2'd1)      tach_cnt_d = tach_cnt_q + 8'd1;
    else if (step == 2'd3) tach_cnt_d = tach_cnt_q - 8'd1;
    if (motorena && !cfg_q[CFG_BRAKE]) begin
      if (cfg_q[CFG_DIR]) pwm_d = {raw, 1'b0};
      else                pwm_d = {1'b0, raw};
    end
  end

  always_comb begin
    rd_data = 8'h00;
    case (rd_addr)
      CH_DUTY: rd_data = duty_q;
      CH_TACH: rd_data = tach_cnt_q;
      CH_CFG:  rd_data = {6'b0, cfg_q};
      CH_STAT: rd_data = {5'b0, climit, tach};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty_q        <= DUTY_RST;
      cfg_q         <= CFG_RST;
      tach_cnt_q    <= 8'h00;
      tach_prev_q   <= 2'b00;
      pwm_q         <= 2'b00;
      climit_hold_q <= 1'b0;
    end else begin
      duty_q        <= duty_d;
      cfg_q         <= cfg_d;
      tach_cnt_q    <= tach_cnt_d;
      tach_prev_q   <= tach_prev_d;
      pwm_q         <= pwm_d;
      climit_hold_q <= climit_hold_d;
    end
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/bdc_motor_ctrl.sv
// Three-channel brushed-DC motor controller core: input synchronizers, SPI
// register interface, shared PWM timebase, watchdog-guarded motor enable.
module bdc_motor_ctrl
  import bdc_motor_ctrl_pkg::*;
#(
  parameter int         PWM_PRESCALE = 4,
  parameter int         WDOG_UNIT    = 64,
  parameter logic [7:0] HW_CONFIG    = HW_CONFIG_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       ss,
  input  logic       mosi,
  output logic       miso,
  input  logic       tstn,
  input  logic       wdogdisn,
  input  logic       currentlimit0,
  input  logic       currentlimit1,
  input  logic       currentlimit2,
  input  logic [1:0] tach0,
  input  logic [1:0] tach1,
  input  logic [1:0] tach2,
  output logic       motorena,
  output logic [1:0] pwm0,
  output logic [1:0] pwm1,
  output logic [1:0] pwm2
);

  localparam int NSYNC = 14;
  localparam int PS_W  = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
  localparam int WD_W  = 9 + $clog2(WDOG_UNIT);

  logic [NSYNC-1:0] sync_in, sync1_q, sync2_q;
  logic sclk_s, ss_s, mosi_s, tstn_s, wdogdisn_s;
  logic [2:0] cl_s;

  assign sync_in = {tach2, tach1, tach0, currentlimit2, currentlimit1, currentlimit0,
                    wdogdisn, tstn, mosi, ss, sclk};
  assign sclk_s     = sync2_q[0];
  assign ss_s       = sync2_q[1];
  assign mosi_s     = sync2_q[2];
  assign tstn_s     = sync2_q[3];
  assign wdogdisn_s = sync2_q[4];
  assign cl_s       = sync2_q[7:5];

  logic sclk_prev_q;
  logic [4:0] bit_cnt_q, bit_cnt_d;
  logic [14:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d, rd_data;
  logic sclk_rise, frame_done, wr_stb;
  logic [7:0] hdr, wr_data;
  logic [15:0] frame;
  logic [3:0] wr_addr;

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign hdr       = {rx_q[6:0], mosi_s};
  assign frame     = {rx_q, mosi_s};
  assign wr_addr   = frame[14:11];
  assign wr_data   = frame[7:0];
  assign wr_stb    = frame_done & ~frame[15];

  // Bits past the 16th are ignored; only a deasserted select rearms the frame.
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    frame_done = 1'b0;
    if (!ss_s) begin
      bit_cnt_d = 5'd0;
      tx_d      = 8'h00;
    end else if (sclk_rise && bit_cnt_q != 5'd16) begin
      bit_cnt_d = bit_cnt_q + 5'd1;
      rx_d      = frame[14:0];
      tx_d      = {tx_q[6:0], 1'b0};
      if (bit_cnt_q == 5'd7 && hdr[7]) tx_d = rd_data;
      if (bit_cnt_q == 5'd15) frame_done = 1'b1;
    end
  end

  assign miso = ss ? tx_q[7] : 1'bz;

  logic [7:0] ch_rd [3];
  logic [1:0] ch_pwm [3];
  logic [7:0] wdiv_q, wdiv_d;
  logic [3:0] wctl_q, wctl_d;
  logic tripped_q, tripped_d, motorena_q, motorena_d, wd_run;
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d, wd_limit;

  always_comb begin
    rd_data = 8'h00;
    case (hdr[6:3])
      ADDR_ZERO:  rd_data = 8'h00;
      ADDR_HWCFG: rd_data = HW_CONFIG;
      ADDR_WDIV:  rd_data = wdiv_q;
      ADDR_WCTL:  rd_data = {tripped_q, 3'b000, wctl_q};
      default: begin
        case (hdr[6:5])
          2'd0:    rd_data = ch_rd[0];
          2'd1:    rd_data = ch_rd[1];
          2'd2:    rd_data = ch_rd[2];
          default: rd_data = 8'h00;
        endcase
      end
    endcase
  end

  assign wd_limit = WD_W'(wdiv_q) * WD_W'(WDOG_UNIT);
  assign wd_run   = wctl_q[WCTL_MENA] & wdogdisn_s & (wdiv_q != 8'h00) & ~tripped_q;

  // A completed frame kicks the watchdog and overrides a same-cycle trip.
  always_comb begin
    wdiv_d    = wdiv_q;
    wctl_d    = wctl_q;
    tripped_d = tripped_q;
    wd_cnt_d  = wd_cnt_q;
    if (wd_run) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
      if (wd_cnt_d >= wd_limit) tripped_d = 1'b1;
    end
    if (frame_done) begin
      wd_cnt_d  = '0;
      tripped_d = tripped_q;
    end
    if (wr_stb && wr_addr == ADDR_WDIV) wdiv_d = wr_data;
    if (wr_stb && wr_addr == ADDR_WCTL) begin
      wctl_d = wr_data[3:0];
      if (wr_data[WCTL_TRIP]) tripped_d = 1'b0;
    end
    motorena_d = wctl_d[WCTL_MENA] & ~tripped_d;
  end

  logic [PS_W-1:0] ps_q, ps_d;
  logic [7:0] pwm_cnt_q, pwm_cnt_d;
  logic pwm_tick, pwm_wrap;

  assign pwm_tick = (ps_q == PS_W'(PWM_PRESCALE - 1));
  assign pwm_wrap = pwm_tick & (pwm_cnt_q == 8'hFF);

  always_comb begin
    ps_d      = pwm_tick ? '0 : ps_q + 1'b1;
    pwm_cnt_d = pwm_tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      sclk_prev_q <= 1'b0;
      bit_cnt_q   <= 5'd0;
      rx_q        <= '0;
      tx_q        <= 8'h00;
      wdiv_q      <= WDIV_RST;
      wctl_q      <= WCTL_RST;
      tripped_q   <= 1'b0;
      motorena_q  <= 1'b0;
      wd_cnt_q    <= '0;
      ps_q        <= '0;
      pwm_cnt_q   <= 8'h00;
    end else begin
      sync1_q     <= sync_in;
      sync2_q     <= sync1_q;
      sclk_prev_q <= sclk_s;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      wdiv_q      <= wdiv_d;
      wctl_q      <= wctl_d;
      tripped_q   <= tripped_d;
      motorena_q  <= motorena_d;
      wd_cnt_q    <= wd_cnt_d;
      ps_q        <= ps_d;
      pwm_cnt_q   <= pwm_cnt_d;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_ch
    bdc_channel u_ch (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_stb && (wr_addr[3:2] == 2'(i))),
      .wr_addr  (wr_addr[1:0]),
      .wr_data  (wr_data),
      .rd_addr  (hdr[4:3]),
      .rd_data  (ch_rd[i]),
      .pwm_cnt  (pwm_cnt_q),
      .pwm_wrap (pwm_wrap),
      .motorena (motorena_q),
      .climit   (cl_s[i]),
      .tach     (sync2_q[8+2*i +: 2]),
      .pwm      (ch_pwm[i])
    );
  end

  // The test strap is synchronized for status use only; header pad bits carry nothing.
  logic unused_bits;
  assign unused_bits = ^{tstn_s, hdr[2:0]};

  assign motorena = motorena_q;
  assign pwm0     = ch_pwm[0];
  assign pwm1     = ch_pwm[1];
  assign pwm2     = ch_pwm[2];

endmodule

// File: tb/tb_bdc_motor_ctrl.sv
// Directed bench for bdc_motor_ctrl: SPI register traffic, watchdog trip,
// tach decoding, PWM duty/direction/brake and cycle-by-cycle current limit.
`timescale 1ns/1ps
module tb_bdc_motor_ctrl;

  logic clk = 1'b0, reset = 1'b1;
  logic sclk = 1'b1, ss = 1'b0, mosi = 1'b0, tstn = 1'b1, wdogdisn = 1'b1;
  logic currentlimit0 = 1'b0, currentlimit1 = 1'b0, currentlimit2 = 1'b0;
  logic [1:0] tach0 = 2'b00, tach1 = 2'b00, tach2 = 2'b00;
  wire miso;
  logic motorena;
  logic [1:0] pwm0, pwm1, pwm2;

  pullup (miso);

  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];
  string tag_q[$];
  int duties[3] = '{8'h40, 8'hC0, 8'h80};

  always #5 clk = ~clk;

  bdc_motor_ctrl dut (
    .clk(clk), .reset(reset), .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso),
    .tstn(tstn), .wdogdisn(wdogdisn),
    .currentlimit0(currentlimit0), .currentlimit1(currentlimit1), .currentlimit2(currentlimit2),
    .tach0(tach0), .tach1(tach1), .tach2(tach2),
    .motorena(motorena), .pwm0(pwm0), .pwm1(pwm1), .pwm2(pwm2)
  );

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic spi_frame(input logic [15:0] word, input int nbits, output logic [7:0] rd);
    rd = 8'h00;
    ss = 1'b1;
    wait_clk(4);
    for (int i = 15; i > 15 - nbits; i--) begin
      sclk = 1'b0;
      mosi = word[i];
      wait_clk(4);
      if (i < 8) rd[i] = miso;
      sclk = 1'b1;
      wait_clk(4);
    end
    wait_clk(2);
    ss = 1'b0;
    wait_clk(4);
  endtask

  task automatic spi_write(input logic [3:0] addr, input logic [7:0] data);
    logic [7:0] dummy;
    spi_frame({1'b0, addr, 3'b000, data}, 16, dummy);
  endtask

  task automatic spi_read(input logic [3:0] addr, input int exp, input string tag);
    logic [7:0] rd;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    spi_frame({1'b1, addr, 3'b000, 8'h00}, 16, rd);
    check(tag_q.pop_front(), rd, exp_q.pop_front());
  endtask

  task automatic measure(input int ch, output int hi0, output int hi1);
    logic [1:0] p;
    hi0 = 0;
    hi1 = 0;
    for (int k = 0; k < 1024; k++) begin
      @(negedge clk);
      p = (ch == 0) ? pwm0 : (ch == 1) ? pwm1 : pwm2;
      if (p[0]) hi0++;
      if (p[1]) hi1++;
    end
  endtask

  task automatic pwm_check(input int ch, input int exp0, input int exp1, input string tag);
    int hi0, hi1;
    exp_q.push_back(exp0);
    exp_q.push_back(exp1);
    measure(ch, hi0, hi1);
    check({tag, "_fwd"}, hi0, exp_q.pop_front());
    check({tag, "_rev"}, hi1, exp_q.pop_front());
  endtask

  task automatic wait_rise_pwm0(output logic ok);
    logic prev;
    ok = 1'b0;
    for (int k = 0; k < 2000 && !ok; k++) begin
      prev = pwm0[0];
      @(negedge clk);
      if (!prev && pwm0[0]) ok = 1'b1;
    end
  endtask

  initial begin
    logic ok;
    logic [7:0] dummy;

    wait_clk(5);
    reset = 1'b0;
    wait_clk(5);
    check("rst_motorena", motorena, 1'b0);
    check("rst_pwm", {pwm2, pwm1, pwm0}, 6'b0);
    check("miso_hiz", miso, 1'b1);
    ss = 1'b1;
    wait_clk(4);
    check("miso_driven_byte0", miso, 1'b0);
    ss = 1'b0;
    wait_clk(4);

    spi_read(4'hD, 8'h30, "hwcfg");
    spi_read(4'h0, 8'h00, "rst_duty0");
    spi_read(4'hE, 8'hFF, "rst_wdiv");
    spi_read(4'hF, 8'h00, "rst_wctl");
    spi_read(4'hC, 8'h00, "reg_c");

    spi_write(4'hE, 8'h10);
    spi_read(4'hE, 8'h10, "wdiv");
    spi_frame({1'b0, 4'hE, 3'b000, 8'h55}, 12, dummy);
    spi_read(4'hE, 8'h10, "short_frame");

    spi_write(4'hF, 8'h01);
    spi_read(4'hF, 8'h01, "wctl_01");
    spi_write(4'hF, 8'h03);
    spi_read(4'hF, 8'h03, "wctl_03");
    spi_write(4'hF, 8'h07);
    spi_read(4'hF, 8'h07, "wctl_07");
    check("motorena_off", motorena, 1'b0);

    spi_write(4'hF, 8'h0F);
    check("motorena_on", motorena, 1'b1);
    wait_clk(10000);
    check("motorena_tripped", motorena, 1'b0);
    spi_read(4'hF, 8'h8F, "wctl_tripped");
    spi_write(4'hF, 8'h80);
    spi_write(4'hF, 8'h0F);
    spi_read(4'hF, 8'h0F, "wctl_cleared");
    check("motorena_rearmed", motorena, 1'b1);

    wdogdisn = 1'b0;
    wait_clk(20000);
    check("wdog_disabled", motorena, 1'b1);
    spi_read(4'hF, 8'h0F, "wctl_no_trip");

    tach0 = 2'b01; wait_clk(6);
    spi_read(4'h1, 8'h01, "tach0_up");
    tach0 = 2'b00; wait_clk(6);
    spi_read(4'h1, 8'h00, "tach0_down");
    tach0 = 2'b10; wait_clk(6);
    spi_read(4'h1, 8'hFF, "tach0_wrap");
    tach1 = 2'b01; wait_clk(6);
    tach1 = 2'b11; wait_clk(6);
    tach1 = 2'b10; wait_clk(6);
    tach1 = 2'b00; wait_clk(6);
    spi_read(4'h5, 8'h04, "tach1_fwd4");
    tach2 = 2'b11; wait_clk(6);
    spi_read(4'h9, 8'h00, "tach2_jump");
    spi_read(4'hB, 8'h03, "status2");

    for (int ch = 0; ch < 3; ch++) begin
      for (int d = 0; d < 3; d++) begin
        spi_write(4'(4 * ch), 8'(duties[d]));
        pwm_check(ch, duties[d] * 4, 0, $sformatf("pwm%0d_duty%0h", ch, duties[d]));
      end
    end
    spi_read(4'h0, 8'h80, "duty0_readback");

    spi_write(4'h2, 8'h01);
    spi_read(4'h2, 8'h01, "cfg0_dir");
    pwm_check(0, 0, 512, "pwm0_dir1");
    spi_write(4'h2, 8'h03);
    pwm_check(0, 0, 0, "pwm0_brake");
    spi_write(4'h2, 8'h00);

    wait_rise_pwm0(ok);
    check("pwm0_rise_seen", ok, 1'b1);
    wait_clk(100);
    currentlimit0 = 1'b1;
    wait_clk(8);
    currentlimit0 = 1'b0;
    wait_clk(4);
    check("climit_cut", pwm0, 2'b00);
    wait_clk(200);
    check("climit_hold", pwm0, 2'b00);
    wait_rise_pwm0(ok);
    check("climit_wrap_seen", ok, 1'b1);
    wait_clk(20);
    check("climit_recover", pwm0, 2'b01);

    currentlimit0 = 1'b1;
    wait_clk(4);
    spi_read(4'h3, 8'h06, "status0_climit");
    currentlimit0 = 1'b0;
    wait_clk(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
